// File: rtl/and_sweep_checker_pkg.sv
// Shared definitions for the on-chip AND sweep checker: FSM states and
// error-counter saturation.
package and_sweep_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sweepState_t;

    localparam logic [15:0] ERR_MAX = 16'hFFFF;

    // Mismatch counter increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [15:0] satIncrement(input logic [15:0] count);
        return (count == ERR_MAX) ? count : count + 16'd1;
    endfunction

endpackage

// File: rtl/and_sweep_checker_operand_sweep.sv
// Nested A/B operand counter: B is the inner loop, A the outer, both stepping
// by STEP while below LIMIT. The last vector is held once the sweep is exhausted.
module and_sweep_checker_operand_sweep #(
    parameter int WIDTH = 32,
    parameter int STEP  = 10,
    parameter int LIMIT = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] opA,
    output logic [WIDTH-1:0] opB,
    output logic             lastVector
);

    localparam logic [WIDTH:0] STEP_EXT  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] LIMIT_EXT = (WIDTH + 1)'(LIMIT);

    logic [WIDTH:0] nextA;
    logic [WIDTH:0] nextB;
    logic           wrapB;

    // One extra bit keeps the LIMIT compare honest near the top of the range.
    assign nextA      = {1'b0, opA} + STEP_EXT;
    assign nextB      = {1'b0, opB} + STEP_EXT;
    assign wrapB      = (nextB >= LIMIT_EXT);
    assign lastVector = wrapB && (nextA >= LIMIT_EXT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opA <= '0;
            opB <= '0;
        end else if (clear) begin
            opA <= '0;
            opB <= '0;
        end else if (advance && !lastVector) begin
            if (wrapB) begin
                opB <= '0;
                opA <= nextA[WIDTH-1:0];
            end else begin
                opB <= nextB[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/and_sweep_checker.sv
// Self-checking sweep engine for the bitwise-AND datapath: drives every A/B
// vector, waits SETTLE cycles, then compares the unit's result with A & B.
module and_sweep_checker
    import and_sweep_checker_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STEP   = 10,
    parameter int LIMIT  = 1000,
    parameter int SETTLE = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_result
);

    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    sweepState_t         stateReg;
    sweepState_t         stateNext;
    logic [SETTLE_W-1:0] settleReg;
    logic [SETTLE_W-1:0] settleNext;
    logic                beginSweep;
    logic                advance;
    logic                checkActive;
    logic                lastVector;
    logic                mismatch;
    logic                firstSeenReg;

    and_sweep_checker_operand_sweep #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .LIMIT (LIMIT)
    ) operandSweep (
        .clock      (clock),
        .reset      (reset),
        .clear      (beginSweep),
        .advance    (advance),
        .opA        (dut_a),
        .opB        (dut_b),
        .lastVector (lastVector)
    );

    assign mismatch = (dut_result != (dut_a & dut_b));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            settleReg <= '0;
        end else begin
            stateReg  <= stateNext;
            settleReg <= settleNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        settleNext  = settleReg;
        beginSweep  = 1'b0;
        advance     = 1'b0;
        checkActive = 1'b0;
        case (stateReg)
            IDLE, DONE: begin
                if (start) begin
                    beginSweep = 1'b1;
                    settleNext = '0;
                    stateNext  = DRIVE;
                end
            end
            DRIVE: begin
                if (settleReg == SETTLE_LAST) begin
                    settleNext = '0;
                    stateNext  = CHECK;
                end else begin
                    settleNext = settleReg + SETTLE_W'(1);
                end
            end
            CHECK: begin
                checkActive = 1'b1;
                // Operands hold on the final vector so DONE still shows it.
                if (lastVector) begin
                    stateNext = DONE;
                end else begin
                    advance   = 1'b1;
                    stateNext = DRIVE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_a       <= '0;
            fail_b       <= '0;
            fail_result  <= '0;
            firstSeenReg <= 1'b0;
        end else if (beginSweep) begin
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_a       <= '0;
            fail_b       <= '0;
            fail_result  <= '0;
            firstSeenReg <= 1'b0;
        end else if (checkActive) begin
            if (mismatch) begin
                err_count    <= satIncrement(err_count);
                firstSeenReg <= 1'b1;
                if (!firstSeenReg) begin
                    fail_a      <= dut_a;
                    fail_b      <= dut_b;
                    fail_result <= dut_result;
                end
            end
            // The final vector's own outcome must count toward pass.
            if (lastVector) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == 16'd0) && !mismatch;
            end
        end
    end

endmodule

// File: tb/tb_and_sweep_checker.sv
// Bench for and_sweep_checker: a default-size instance and a small instance,
// each fed by a fault-injecting AND model and checked against a loop-based reference.
module tb_and_sweep_checker;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start   [2];
    logic [W-1:0]  dutA    [2];
    logic [W-1:0]  dutB    [2];
    logic [W-1:0]  dutRes  [2];
    logic [W-1:0]  failA   [2];
    logic [W-1:0]  failB   [2];
    logic [W-1:0]  failR   [2];
    logic          busy    [2];
    logic          done    [2];
    logic          pass    [2];
    logic [15:0]   errCnt  [2];

    // Fault model controls: 0 none, 1 bit0 stuck-at-1, 2 single vector xor 1, 3 hashed vectors.
    int            faultMode [2];
    logic [W-1:0]  faultA    [2];
    logic [W-1:0]  faultB    [2];
    int unsigned   faultSeed [2];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    function automatic int stepOf(int u);
        return (u == 0) ? 10 : 7;
    endfunction
    function automatic int limitOf(int u);
        return (u == 0) ? 1000 : 50;
    endfunction
    function automatic int settleOf(int u);
        return (u == 0) ? 2 : 1;
    endfunction

    function automatic logic [W-1:0] faultyAnd(int mode, logic [W-1:0] fa, logic [W-1:0] fb,
                                               int unsigned seed, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        r = a & b;
        case (mode)
            1: r = r | W'(1);
            2: if (a == fa && b == fb) r = r ^ W'(1);
            3: if ((((a * 31) + (b * 17)) ^ seed) % 13 == 0) r = r ^ (32'd1 << (seed % 32));
            default: ;
        endcase
        return r;
    endfunction

    assign dutRes[0] = faultyAnd(faultMode[0], faultA[0], faultB[0], faultSeed[0], dutA[0], dutB[0]);
    assign dutRes[1] = faultyAnd(faultMode[1], faultA[1], faultB[1], faultSeed[1], dutA[1], dutB[1]);

    and_sweep_checker #(.WIDTH(W), .STEP(10), .LIMIT(1000), .SETTLE(2)) dutDef (
        .clock(clock), .reset(reset), .start(start[0]),
        .dut_a(dutA[0]), .dut_b(dutB[0]), .dut_result(dutRes[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errCnt[0]),
        .fail_a(failA[0]), .fail_b(failB[0]), .fail_result(failR[0])
    );

    and_sweep_checker #(.WIDTH(W), .STEP(7), .LIMIT(50), .SETTLE(1)) dutSmall (
        .clock(clock), .reset(reset), .start(start[1]),
        .dut_a(dutA[1]), .dut_b(dutB[1]), .dut_result(dutRes[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errCnt[1]),
        .fail_a(failA[1]), .fail_b(failB[1]), .fail_result(failR[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Walks the operand grid with plain loops and applies the fault model.
    task automatic refModel(input int u, output int errs, output logic [W-1:0] fa,
                            output logic [W-1:0] fb, output logic [W-1:0] fr);
        errs = 0;
        fa = '0;
        fb = '0;
        fr = '0;
        for (int a = 0; a < limitOf(u); a += stepOf(u)) begin
            for (int b = 0; b < limitOf(u); b += stepOf(u)) begin
                logic [W-1:0] got;
                got = faultyAnd(faultMode[u], faultA[u], faultB[u], faultSeed[u], a, b);
                if (got != (a & b)) begin
                    if (errs == 0) begin
                        fa = a;
                        fb = b;
                        fr = got;
                    end
                    if (errs < 65535) errs++;
                end
            end
        end
    endtask

    task automatic runSweep(input int u, input string name, input int pulse1, input int pulse2,
                            input int expErrs, input bit expPass,
                            input int efa, input int efb, input int efr);
        int cyc, nB, nVec, period, v, seqErr, budget;
        nB     = (limitOf(u) + stepOf(u) - 1) / stepOf(u);
        nVec   = nB * nB;
        period = settleOf(u) + 1;
        budget = nVec * period + 50;
        @(negedge clock) start[u] = 1'b1;
        @(negedge clock) start[u] = 1'b0;
        check($sformatf("%s/busy_on_start", name), 64'(busy[u]), 64'(1));
        check($sformatf("%s/done_cleared", name), 64'(done[u]), 64'(0));
        check($sformatf("%s/err_cleared", name), 64'(errCnt[u]), 64'(0));
        cyc = 0;
        seqErr = 0;
        while (!done[u] && cyc < budget) begin
            v = cyc / period;
            if (v < nVec) begin
                if (dutA[u] != W'((v / nB) * stepOf(u)) || dutB[u] != W'((v % nB) * stepOf(u)) || !busy[u])
                    seqErr++;
            end
            start[u] = (cyc == pulse1 || cyc == pulse2);
            @(negedge clock);
            cyc++;
        end
        start[u] = 1'b0;
        $display("run %s: cycles=%0d err_count=%0d pass=%0b fail=(%0d,%0d)->%0d",
                 name, cyc, errCnt[u], pass[u], failA[u], failB[u], failR[u]);
        check($sformatf("%s/cycles", name), 64'(cyc), 64'(nVec * period));
        check($sformatf("%s/operand_seq", name), 64'(seqErr), 64'(0));
        check($sformatf("%s/err_count", name), 64'(errCnt[u]), 64'(expErrs));
        check($sformatf("%s/pass", name), 64'(pass[u]), 64'(expPass));
        check($sformatf("%s/fail_a", name), 64'(failA[u]), 64'(efa));
        check($sformatf("%s/fail_b", name), 64'(failB[u]), 64'(efb));
        check($sformatf("%s/fail_result", name), 64'(failR[u]), 64'(efr));
        check($sformatf("%s/busy_end", name), 64'(busy[u]), 64'(0));
        check($sformatf("%s/last_a", name), 64'(dutA[u]), 64'((nB - 1) * stepOf(u)));
        check($sformatf("%s/last_b", name), 64'(dutB[u]), 64'((nB - 1) * stepOf(u)));
        repeat (3) @(negedge clock);
        check($sformatf("%s/done_held", name), 64'(done[u]), 64'(1));
    endtask

    typedef struct {
        int mode;
        int fa;
        int fb;
        int p1;
        int p2;
        int errs;
        bit pass;
        int efa;
        int efb;
        int efr;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int eErrs;
        logic [W-1:0] eA, eB, eR;

        // Small instance grid is {0,7,...,49}; hand-derived expectations.
        tbl[0] = '{0, 0, 0, -1, -1, 0, 1'b1, 0, 0, 0};
        // a&b is odd only when both operands are odd (4x4 vectors), so 64-16 fail.
        tbl[1] = '{1, 0, 0, 3, 40, 48, 1'b0, 0, 0, 1};
        // 21 & 35 = 1, flipped to 0.
        tbl[2] = '{2, 21, 35, -1, -1, 1, 1'b0, 21, 35, 0};
        // Fault on the very last vector: 49 & 49 = 49, flipped to 48.
        tbl[3] = '{2, 49, 49, 0, -1, 1, 1'b0, 49, 49, 48};

        for (int u = 0; u < 2; u++) begin
            start[u]     = 1'b0;
            faultMode[u] = 0;
            faultA[u]    = '0;
            faultB[u]    = '0;
            faultSeed[u] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset%0d/busy", u), 64'(busy[u]), 64'(0));
            check($sformatf("reset%0d/done", u), 64'(done[u]), 64'(0));
            check($sformatf("reset%0d/pass", u), 64'(pass[u]), 64'(0));
            check($sformatf("reset%0d/err", u), 64'(errCnt[u]), 64'(0));
            check($sformatf("reset%0d/dut_a", u), 64'(dutA[u]), 64'(0));
            check($sformatf("reset%0d/dut_b", u), 64'(dutB[u]), 64'(0));
            check($sformatf("reset%0d/fail_a", u), 64'(failA[u]), 64'(0));
            check($sformatf("reset%0d/fail_b", u), 64'(failB[u]), 64'(0));
            check($sformatf("reset%0d/fail_r", u), 64'(failR[u]), 64'(0));
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle/no_self_start", 64'(busy[0]), 64'(0));

        // Reset at vector 37 with every vector failing: 37 errors already counted.
        faultMode[0] = 1;
        @(negedge clock) start[0] = 1'b1;
        @(negedge clock) start[0] = 1'b0;
        repeat (37 * 3 + 1) @(negedge clock);
        check("mid/err_before_reset", 64'(errCnt[0]), 64'(37));
        check("mid/dut_b_before_reset", 64'(dutB[0]), 64'(370));
        #1 reset = 1'b1;
        #1;
        check("mid/busy_zero", 64'(busy[0]), 64'(0));
        check("mid/err_zero", 64'(errCnt[0]), 64'(0));
        check("mid/dut_b_zero", 64'(dutB[0]), 64'(0));
        check("mid/fail_r_zero", 64'(failR[0]), 64'(0));
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        $display("run mid_reset: err_count after reset=%0d", errCnt[0]);

        // Full default sweep with one faulty vector and start re-pulsed while busy.
        faultMode[0] = 2;
        faultA[0]    = 730;
        faultB[0]    = 990;
        refModel(0, eErrs, eA, eB, eR);
        runSweep(0, "def_single", 100, 12345, eErrs, eErrs == 0, eA, eB, eR);

        // Stuck-at-1 on bit 0: every operand is a multiple of 10, so all 10000 fail.
        faultMode[0] = 1;
        runSweep(0, "def_stuck", -1, -1, 10000, 1'b0, 0, 0, 1);

        for (int i = 0; i < 4; i++) begin
            faultMode[1] = tbl[i].mode;
            faultA[1]    = tbl[i].fa;
            faultB[1]    = tbl[i].fb;
            runSweep(1, $sformatf("tbl%0d", i), tbl[i].p1, tbl[i].p2,
                     tbl[i].errs, tbl[i].pass, tbl[i].efa, tbl[i].efb, tbl[i].efr);
        end

        for (int i = 0; i < 3; i++) begin
            faultMode[1] = 3;
            faultSeed[1] = $urandom;
            refModel(1, eErrs, eA, eB, eR);
            runSweep(1, $sformatf("rand%0d", i), int'($urandom_range(1, 60)), -1,
                     eErrs, eErrs == 0, eA, eB, eR);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
